// File: rtl/assert_time_multi.sv
// assert_time_multi: per-channel timed window checker with start policy, coverage pulses and saturating error count
module assert_time_multi #(
  parameter int NUM_CH = 4,
  parameter int NUM_CKS = 2,
  parameter int ACTION_ON_NEW_START = 0,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    start_event,
  input  logic [NUM_CH-1:0]    test_expr,
  output logic [NUM_CH-1:0]    window,
  output logic [NUM_CH-1:0]    fire_test,
  output logic [NUM_CH-1:0]    fire_start,
  output logic                 fire_any,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [NUM_CH-1:0]    cov_open,
  output logic [NUM_CH-1:0]    cov_close,
  output logic [NUM_CH-1:0]    cov_restart
);
  localparam int CW = $clog2(NUM_CKS + 1);
  localparam int SW = ERR_CNT_W + 7;
  localparam bit POL_OK = ACTION_ON_NEW_START >= 0 && ACTION_ON_NEW_START <= 2;
  localparam int POL = POL_OK ? ACTION_ON_NEW_START : 0;
  if (!POL_OK) begin : g_bad_policy
    $error("assert_time_multi: illegal ACTION_ON_NEW_START=%0d, using ignore policy", ACTION_ON_NEW_START);
  end
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q [NUM_CH];
  state_t state_d [NUM_CH];
  logic [CW-1:0] cnt_q [NUM_CH];
  logic [CW-1:0] cnt_d [NUM_CH];
  logic [NUM_CH-1:0] fire_test_q, fire_test_d, fire_start_q, fire_start_d;
  logic [NUM_CH-1:0] cov_open_q, cov_open_d, cov_close_q, cov_close_d, cov_restart_q, cov_restart_d;
  logic fire_any_q, fire_any_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [SW-1:0] err_sum;
  always_comb begin
    fire_test_d = '0;
    fire_start_d = '0;
    cov_open_d = '0;
    cov_close_d = '0;
    cov_restart_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i] = cnt_q[i];
      window[i] = state_q[i] == ACTIVE;
      if (state_q[i] == IDLE) begin
        if (start_event[i]) begin
          state_d[i] = ACTIVE;
          cnt_d[i] = CW'(NUM_CKS);
          cov_open_d[i] = 1'b1;
        end
      end else begin
        fire_test_d[i] = !test_expr[i];
        fire_start_d[i] = POL == 2 && start_event[i];
        if (POL == 1 && start_event[i]) begin
          cnt_d[i] = CW'(NUM_CKS);
          cov_restart_d[i] = 1'b1;
        end else if (cnt_q[i] == CW'(1)) begin
          state_d[i] = IDLE;
          cnt_d[i] = '0;
          cov_close_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - CW'(1);
        end
      end
    end
    fire_any_d = |{fire_test_d, fire_start_d};
    // wide sum so several channels failing together still saturates correctly
    err_sum = SW'(err_cnt_q) + SW'($countones({fire_test_d, fire_start_d}));
    err_cnt_d = |err_sum[SW-1:ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i] <= '0;
      end
      fire_test_q <= '0;
      fire_start_q <= '0;
      cov_open_q <= '0;
      cov_close_q <= '0;
      cov_restart_q <= '0;
      fire_any_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      fire_test_q <= fire_test_d;
      fire_start_q <= fire_start_d;
      cov_open_q <= cov_open_d;
      cov_close_q <= cov_close_d;
      cov_restart_q <= cov_restart_d;
      fire_any_q <= fire_any_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  assign fire_test = fire_test_q;
  assign fire_start = fire_start_q;
  assign fire_any = fire_any_q;
  assign err_cnt = err_cnt_q;
  assign cov_open = cov_open_q;
  assign cov_close = cov_close_q;
  assign cov_restart = cov_restart_q;
endmodule

// File: tb/tb_assert_time_multi.sv
// tb_assert_time_multi: one DUT per start policy against a remaining-cycles reference model via a scoreboard queue
module tb_assert_time_multi;
  localparam int N = 4;
  localparam int K = 3;
  localparam int EW = 3;
  localparam int MAXE = 7;
  typedef struct packed {
    logic [N-1:0] win, ft, fs, co, cc, cr;
    logic fa;
    logic [EW-1:0] ec;
  } obs_t;
  typedef obs_t [2:0] obs3_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] st = '0;
  logic [N-1:0] te = '1;
  logic [N-1:0] win [3];
  logic [N-1:0] ft [3];
  logic [N-1:0] fs [3];
  logic [N-1:0] co [3];
  logic [N-1:0] cc [3];
  logic [N-1:0] cr [3];
  logic fa [3];
  logic [EW-1:0] ec [3];
  obs3_t sbq [$];
  int rem [3][N];
  int err [3];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  for (genvar p = 0; p < 3; p++) begin : g_dut
    assert_time_multi #(.NUM_CH(N), .NUM_CKS(K), .ACTION_ON_NEW_START(p), .ERR_CNT_W(EW)) dut (
      .clk(clk), .reset(reset), .start_event(st), .test_expr(te),
      .window(win[p]), .fire_test(ft[p]), .fire_start(fs[p]), .fire_any(fa[p]),
      .err_cnt(ec[p]), .cov_open(co[p]), .cov_close(cc[p]), .cov_restart(cr[p]));
  end
  // rem = cycles of window still to come (0 = idle); policy index equals p
  task automatic step(input logic r, input logic [N-1:0] s, input logic [N-1:0] t);
    obs3_t e;
    e = '0;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < N; c++) begin
        if (r) rem[p][c] = 0;
        else if (rem[p][c] == 0) begin
          if (s[c]) begin
            rem[p][c] = K;
            e[p].co[c] = 1'b1;
          end
        end else begin
          e[p].ft[c] = !t[c];
          e[p].fs[c] = p == 2 && s[c];
          if (p == 1 && s[c]) begin
            rem[p][c] = K;
            e[p].cr[c] = 1'b1;
          end else begin
            rem[p][c]--;
            e[p].cc[c] = rem[p][c] == 0;
          end
        end
        e[p].win[c] = rem[p][c] > 0;
      end
      e[p].fa = |{e[p].ft, e[p].fs};
      err[p] = r ? 0 : err[p] + $countones({e[p].ft, e[p].fs});
      if (err[p] > MAXE) err[p] = MAXE;
      e[p].ec = EW'(err[p]);
    end
    reset = r;
    st = s;
    te = t;
    sbq.push_back(e);
  endtask
  initial begin
    obs3_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        cyc++;
        for (int p = 0; p < 3; p++) begin
          a = {win[p], ft[p], fs[p], co[p], cc[p], cr[p], fa[p], ec[p]};
          checks++;
          if (a === e[p]) passes++;
          else $display("FAIL obs pol%0d cyc%0d got win=%h ft=%h fs=%h co=%h cc=%h cr=%h fa=%b ec=%0d want win=%h ft=%h fs=%h co=%h cc=%h cr=%h fa=%b ec=%0d",
            p, cyc, a.win, a.ft, a.fs, a.co, a.cc, a.cr, a.fa, a.ec,
            e[p].win, e[p].ft, e[p].fs, e[p].co, e[p].cc, e[p].cr, e[p].fa, e[p].ec);
        end
      end
    end
  end
  initial begin
    logic [8:0] dir [];
    logic [N-1:0] s, t;
    dir = '{9'h10f, 9'h10f,
            9'h01f, 9'h00f, 9'h00f, 9'h00f, 9'h00f, 9'h00f,
            9'h01f, 9'h00f, 9'h00e, 9'h00f, 9'h00f, 9'h00f,
            9'h01f, 9'h00f, 9'h01f, 9'h00f, 9'h00f, 9'h00f, 9'h00f, 9'h00f,
            9'h01f, 9'h01f, 9'h00f, 9'h00f, 9'h00f, 9'h00f,
            9'h0ff, 9'h000, 9'h000, 9'h00f, 9'h00f, 9'h00f,
            9'h01f, 9'h00f, 9'h10f, 9'h01f, 9'h00f, 9'h00f, 9'h00f, 9'h00f};
    foreach (dir[i]) begin
      @(negedge clk);
      step(dir[i][8], dir[i][7:4], dir[i][3:0]);
    end
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) begin
        s[c] = $urandom_range(0, 3) == 0;
        t[c] = $urandom_range(0, 7) != 0;
      end
      @(negedge clk);
      step($urandom_range(0, 59) == 0, s, t);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sbq.size() == 0) passes++;
    else $display("FAIL drain got %0d pending want 0", sbq.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/assert_time_multi.md
ASSERT_TIME_MULTI -- requirements
Module: assert_time_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent checker channels (legal 1..32).
REQ-002 SHALL have parameter NUM_CKS, default 2, window length in clock cycles (legal >= 1).
REQ-003 SHALL have parameter ACTION_ON_NEW_START, default 0, start-during-window policy: 0 ignore, 1 reset (restart), 2 error.
REQ-004 SHALL have parameter ERR_CNT_W, default 8, width of the error counter.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start_event  input  NUM_CH  per-channel window trigger.
REQ-008 SHALL have port test_expr  input  NUM_CH  per-channel expression that must be 1 in every window cycle.
REQ-009 SHALL have port window  output  NUM_CH  per-channel registered window-active flag.
REQ-010 SHALL have port fire_test  output  NUM_CH  one-cycle pulse: test_expr was 0 inside the window.
REQ-011 SHALL have port fire_start  output  NUM_CH  one-cycle pulse: start_event inside the window under error policy.
REQ-012 SHALL have port fire_any  output  1  OR of all fire_test and fire_start bits.
REQ-013 SHALL have port err_cnt  output  ERR_CNT_W  saturating count of error pulses.
REQ-014 SHALL have port cov_open  output  NUM_CH  one-cycle pulse: window opened.
REQ-015 SHALL have port cov_close  output  NUM_CH  one-cycle pulse: window closed normally.
REQ-016 SHALL have port cov_restart  output  NUM_CH  one-cycle pulse: window restarted under reset policy.

Function
REQ-017 Each channel SHALL be an independent two-state FSM: IDLE (window=0), ACTIVE (window=1), with down-counter cnt of width clog2(NUM_CKS+1).
REQ-018 IDLE with start_event=1 SHALL go to ACTIVE, load cnt=NUM_CKS, and pulse cov_open in the next cycle; window rises the cycle after start_event.
REQ-019 In ACTIVE, every cycle with test_expr=0 SHALL pulse fire_test in the following cycle (one-cycle latency); the start cycle itself is not checked.
REQ-020 In ACTIVE with cnt==1 SHALL return to IDLE and pulse cov_close, unless policy is reset and start_event=1.
REQ-021 In ACTIVE with cnt!=1 and no restart SHALL decrement cnt by 1; window therefore stays high for exactly NUM_CKS cycles.
REQ-022 Policy reset: start_event=1 in ACTIVE (any cnt, including 1) SHALL reload cnt=NUM_CKS, stay ACTIVE, pulse cov_restart; no cov_close.
REQ-023 Policy error: start_event=1 in ACTIVE SHALL pulse fire_start next cycle; cnt/window unaffected.
REQ-024 Policy ignore: start_event=1 in ACTIVE SHALL have no effect.
REQ-025 Start_event in the closing cycle (cnt==1) under ignore/error policy SHALL NOT reopen the window; channel is IDLE next cycle; a new start is taken only from IDLE.
REQ-026 fire_test and fire_start on the same channel in the same cycle SHALL both assert.
REQ-027 fire_any SHALL be registered in the same cycle as the fire pulses it summarizes.
REQ-028 err_cnt SHALL add the total number of fire_test and fire_start bits set in a cycle, and saturate at 2^ERR_CNT_W-1 without wrapping.
REQ-029 Illegal ACTION_ON_NEW_START SHALL emit a simulation error message at time 0 and the block SHALL behave as ignore policy.

Reset
REQ-030 reset=1 at a clock edge SHALL force all channels to IDLE, cnt=0, and clear window, fire_*, fire_any, err_cnt, cov_* to 0 in the next cycle.
REQ-031 reset asserted mid-window SHALL abort the window without cov_close or fire pulses; start_event sampled during reset SHALL be ignored.
REQ-032 The first cycle after reset deassertion SHALL accept start_event normally.

Verification
REQ-033 NUM_CKS=3, ch0 start at cycle 0, test_expr=1 -> window=1 cycles 1-3, cov_open cycle 1, cov_close cycle 4, no fire.
REQ-034 NUM_CKS=3, test_expr=0 at cycle 2 only -> fire_test[0]=1 cycle 3 only, fire_any=1 cycle 3, err_cnt=1.
REQ-035 Policy reset, NUM_CKS=3, starts at cycles 0 and 2 -> cov_restart cycle 3, window=1 cycles 1-5, cov_close cycle 6.
REQ-036 Policy error, starts at cycles 0 and 1 -> fire_start[0] cycle 2, window still closes after cycle 3.
REQ-037 ERR_CNT_W=2, all 4 channels fail simultaneously twice -> err_cnt saturates at 3.
REQ-038 reset at cycle 2 of an open window -> window=0 cycle 3, no cov_close, err_cnt=0; start at cycle 3 opens window cycle 4.
